// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared codes and types for the writeback arbiter
package wb_arbiter_pkg;
   localparam int RD_W   = 5;
   localparam int DATA_W = 32;

   localparam logic REG_WRITE    = 1'b1;
   localparam logic REG_NO_WRITE = 1'b0;

   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_DRAIN  = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - result buffer holding long-latency writebacks
module wb_result_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  wb_entry_t                push_entry,
   output wb_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter between pipeline and long-latency unit
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pipe_valid,
   input  logic [RD_W-1:0]   pipe_rd,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              lu_valid,
   input  logic [RD_W-1:0]   lu_rd,
   input  logic [DATA_W-1:0] lu_data,
   output logic              lu_ready,
   output logic              rf_we,
   output logic [RD_W-1:0]   rf_rd,
   output logic [DATA_W-1:0] rf_data,
   output logic              stall
);
   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [PW:0]   DEPTH_C     = (PW+1)'(DEPTH);
   localparam logic [PW:0]   ONE_C       = (PW+1)'(1);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

   arb_state_e    state;
   arb_state_e    state_next;
   logic [SW-1:0] starve;
   logic [PW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   wb_entry_t     head;
   wb_entry_t     grant_entry;
   logic          grant_valid;
   logic          blocked;

   assign lu_ready = (count < DEPTH_C);
   assign push     = lu_valid && lu_ready;
   assign blocked  = (state == ARB_NORMAL) && pipe_valid && !empty;

   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .push_entry ({lu_rd, lu_data}),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= ARB_NORMAL;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ARB_NORMAL: if (blocked && starve == STARVE_LAST) state_next = ARB_DRAIN;
         ARB_DRAIN:  if (empty || (count == ONE_C && !push)) state_next = ARB_NORMAL;
         default:    state_next = ARB_NORMAL;
      endcase
   end

   // Pipeline wins in NORMAL; DRAIN hands every cycle to the buffer head.
   always_comb begin
      stall       = (state == ARB_DRAIN);
      grant_valid = 1'b0;
      grant_entry = head;
      pop         = 1'b0;
      if (state == ARB_NORMAL && pipe_valid) begin
         grant_valid = 1'b1;
         grant_entry = {pipe_rd, pipe_data};
      end else if (!empty) begin
         grant_valid = 1'b1;
         pop         = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || pop || empty) starve <= '0;
      else if (blocked)          starve <= starve + 1'b1;
   end

   // A grant to rd 0 is consumed but never reaches the register file.
   always_ff @(posedge clock) begin
      if (reset) begin
         rf_we   <= REG_NO_WRITE;
         rf_rd   <= '0;
         rf_data <= '0;
      end else begin
         rf_we <= (grant_valid && grant_entry.rd != '0) ? REG_WRITE : REG_NO_WRITE;
         if (grant_valid) begin
            rf_rd   <= grant_entry.rd;
            rf_data <= grant_entry.data;
         end
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;
   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic        stall;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   bit          m_drain;
   int          m_starve;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clock      (clock),
      .reset      (reset),
      .pipe_valid (pipe_valid),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .lu_valid   (lu_valid),
      .lu_rd      (lu_rd),
      .lu_data    (lu_data),
      .lu_ready   (lu_ready),
      .rf_we      (rf_we),
      .rf_rd      (rf_rd),
      .rf_data    (rf_data),
      .stall      (stall)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the buffer is a plain queue; blocked cycles are counted and a drain
   // phase empties the queue before the pipeline is served again.
   task automatic model_step();
      ent_t g;
      bit   gv;
      bit   blocked;
      bit   acc;
      if (reset) begin
         mq.delete();
         m_drain  = 0;
         m_starve = 0;
         m_we     = 0;
         m_rd     = '0;
         m_data   = '0;
         return;
      end
      acc     = lu_valid && (mq.size() < DEPTH);
      blocked = !m_drain && pipe_valid && (mq.size() > 0);
      gv      = 1;
      if (!m_drain && pipe_valid) begin
         g.rd   = pipe_rd;
         g.data = pipe_data;
      end else if (mq.size() > 0) begin
         g = mq.pop_front();
      end else begin
         gv = 0;
      end
      if (acc) mq.push_back('{lu_rd, lu_data});
      if (m_drain) begin
         m_starve = 0;
         if (mq.size() == 0) m_drain = 0;
      end else begin
         if (blocked && m_starve == STARVE_LIMIT - 1) m_drain = 1;
         m_starve = blocked ? m_starve + 1 : 0;
      end
      m_we = gv && (g.rd != 0);
      if (gv) begin
         m_rd   = g.rd;
         m_data = g.data;
      end
   endtask

   task automatic compare();
      chk("rf_we",    {31'd0, rf_we},    {31'd0, m_we});
      chk("rf_rd",    {27'd0, rf_rd},    {27'd0, m_rd});
      chk("rf_data",  rf_data,           m_data);
      chk("stall",    {31'd0, stall},    {31'd0, m_drain});
      chk("lu_ready", {31'd0, lu_ready}, {31'd0, (mq.size() < DEPTH)});
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      compare();
   endtask

   task automatic cyc(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
      pipe_valid = pv;
      pipe_rd    = prd;
      pipe_data  = pd;
      lu_valid   = lv;
      lu_rd      = lrd;
      lu_data    = ld;
      step();
   endtask

   task automatic idle();
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      int  wait_cycles;
      bit  accepted;
      reset = 1'b1;
      pipe_valid = 0; pipe_rd = '0; pipe_data = '0;
      lu_valid = 0; lu_rd = '0; lu_data = '0;
      step();
      step();
      chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
      chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
      chk("reset_rf_data", rf_data, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_lu_ready", {31'd0, lu_ready}, 32'd1);
      reset = 1'b0;

      // Single long-latency result into an idle arbiter: no bypass, one-cycle write.
      cyc(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEAD_BEEF);
      chk("lu_nobypass_we", {31'd0, rf_we}, 32'd0);
      chk("lu_ready_after_push", {31'd0, lu_ready}, 32'd1);
      idle();
      chk("lu_write_we", {31'd0, rf_we}, 32'd1);
      chk("lu_write_rd", {27'd0, rf_rd}, 32'd5);
      chk("lu_write_data", rf_data, 32'hDEAD_BEEF);
      idle();

      // Pipeline beats a buffered entry, which follows on the next cycle.
      cyc(1, 5'd1, 32'hAA, 1, 5'd7, 32'h22);
      cyc(1, 5'd3, 32'h11, 0, 5'd0, 32'd0);
      chk("prio_pipe_rd", {27'd0, rf_rd}, 32'd3);
      chk("prio_pipe_data", rf_data, 32'h11);
      idle();
      chk("prio_fifo_rd", {27'd0, rf_rd}, 32'd7);
      chk("prio_fifo_data", rf_data, 32'h22);
      chk("prio_no_stall", {31'd0, stall}, 32'd0);
      idle();

      // Starvation: four blocked cycles force a drain of rd 9.
      cyc(1, 5'd2, 32'h2, 1, 5'd9, 32'h99);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 5'(4 + i), 32'(i), 0, 5'd0, 32'd0);
         chk("starve_stall", {31'd0, stall}, (i == 3) ? 32'd1 : 32'd0);
      end
      cyc(1, 5'd20, 32'h20, 0, 5'd0, 32'd0);
      chk("drain_rd", {27'd0, rf_rd}, 32'd9);
      chk("drain_exit_stall", {31'd0, stall}, 32'd0);
      idle();

      // Full buffer: third offer held until a pop frees a slot.
      cyc(1, 5'd1, 32'h1, 1, 5'd10, 32'hA0);
      cyc(1, 5'd2, 32'h2, 1, 5'd11, 32'hB0);
      chk("full_lu_ready", {31'd0, lu_ready}, 32'd0);
      accepted = 0;
      wait_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         bit acc;
         acc = (mq.size() < DEPTH);
         cyc(1, 5'd3, 32'h3, 1, 5'd12, 32'hC0);
         if (acc) begin
            accepted = 1;
            wait_cycles = i;
            break;
         end
      end
      chk("held_offer_accepted", {31'd0, accepted}, 32'd1);
      chk("held_offer_wait", 32'(wait_cycles), 32'd4);
      cyc(1, 5'd4, 32'h4, 0, 5'd0, 32'd0);
      idle();
      idle();

      // rd 0 entry is popped without a register write.
      cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'h55);
      idle();
      chk("rd0_no_we", {31'd0, rf_we}, 32'd0);
      chk("rd0_ready", {31'd0, lu_ready}, 32'd1);
      idle();
      chk("rd0_no_we_after", {31'd0, rf_we}, 32'd0);

      // Pipeline rd 0 is likewise suppressed.
      cyc(1, 5'd0, 32'h77, 0, 5'd0, 32'd0);
      chk("pipe_rd0_no_we", {31'd0, rf_we}, 32'd0);
      idle();

      // Reset in the middle of a drain with two buffered entries.
      cyc(1, 5'd1, 32'h1, 1, 5'd13, 32'hD0);
      cyc(1, 5'd2, 32'h2, 1, 5'd14, 32'hE0);
      for (int i = 0; i < 3; i++) cyc(1, 5'd3, 32'h3, 0, 5'd0, 32'd0);
      chk("pre_reset_stall", {31'd0, stall}, 32'd1);
      reset = 1'b1;
      cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      reset = 1'b0;
      chk("mid_reset_stall", {31'd0, stall}, 32'd0);
      chk("mid_reset_we", {31'd0, rf_we}, 32'd0);
      chk("mid_reset_ready", {31'd0, lu_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("post_reset_no_we", {31'd0, rf_we}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
